// File: rtl/cv32e40p_con_tile_fetch.sv
// OBI data master that walks a 2-D tile (rows of TILE_W words, rows stride_i apart)
// for a consumer, either reading words into rdata_o or writing consumer-supplied words.
module cv32e40p_con_tile_fetch #(
  parameter int TILE_W    = 4,
  parameter int MAX_WORDS = 16,
  parameter int MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        mode_i,
  input  logic [31:0] base_addr_i,
  input  logic [31:0] stride_i,
  input  logic [4:0]  len_i,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] cnt_o,
  output logic [31:0] rdata_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int              OW        = $clog2(MAX_OUTST + 1);
  localparam int              CW        = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam logic [4:0]      MAX_LEN   = 5'(MAX_WORDS);
  localparam logic [CW-1:0]   COL_LAST  = CW'(TILE_W - 1);
  localparam logic [OW-1:0]   OUTST_LIM = OW'(MAX_OUTST);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            mode_q, mode_d;
  logic [31:0]     row_q, row_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     stride_q, stride_d;
  logic [CW-1:0]   col_q, col_d;
  logic [4:0]      len_q, len_d;
  logic [4:0]      issued_q, issued_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            req_q, req_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic            gnt_s;
  logic            rv_s;
  logic [4:0]      len_sat_s;

  assign gnt_s     = req_q & data_gnt_i;
  // Responses only count while a transfer owns the bus; stale ones after reset are dropped.
  assign rv_s      = data_rvalid_i & (state_q != S_IDLE) & (outst_q != '0);
  assign len_sat_s = (len_i > MAX_LEN) ? MAX_LEN : len_i;

  // Next-state, address walk, counters and registered bus controls.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    row_d    = row_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    col_d    = col_q;
    len_d    = len_q;
    issued_d = issued_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    outst_d  = outst_q + OW'(gnt_s) - OW'(rv_s);

    if (rv_s && !mode_q) begin
      rdata_d = data_rdata_i;
      cnt_d   = cnt_q + 32'd1;
    end else begin
      rdata_d = rdata_q;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mode_d   = mode_i;
          row_d    = base_addr_i;
          addr_d   = base_addr_i;
          stride_d = stride_i;
          col_d    = '0;
          len_d    = len_sat_s;
          issued_d = 5'd0;
          outst_d  = '0;
          cnt_d    = 32'd0;
          state_d  = (len_sat_s == 5'd0) ? S_DONE : S_ISSUE;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (gnt_s) begin
          issued_d = issued_q + 5'd1;
          if (mode_q) begin
            cnt_d = cnt_q + 32'd1;
          end else begin
            cnt_d = cnt_d;
          end
          // Column wrap moves to the next row; otherwise step one word along the row.
          if (col_q == COL_LAST) begin
            row_d  = row_q + stride_q;
            addr_d = row_q + stride_q;
            col_d  = '0;
          end else begin
            addr_d = addr_q + 32'd4;
            col_d  = col_q + CW'(1);
          end
          state_d = (issued_d == len_q) ? S_DRAIN : S_ISSUE;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (outst_d == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_d  = (state_d == S_ISSUE) && (issued_d < len_d) && (outst_d < OUTST_LIM);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      row_q    <= 32'd0;
      addr_q   <= 32'd0;
      stride_q <= 32'd0;
      col_q    <= '0;
      len_q    <= 5'd0;
      issued_q <= 5'd0;
      outst_q  <= '0;
      cnt_q    <= 32'd0;
      rdata_q  <= 32'd0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      row_q    <= row_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      col_q    <= col_d;
      len_q    <= len_d;
      issued_q <= issued_d;
      outst_q  <= outst_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      req_q    <= req_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign data_req_o   = req_q;
  assign data_we_o    = mode_q;
  assign data_be_o    = 4'b1111;
  assign data_addr_o  = addr_q;
  assign data_wdata_o = (mode_q && req_q) ? wdata_i : 32'd0;
  assign cnt_o        = cnt_q;
  assign rdata_o      = rdata_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

endmodule
